dec_unbinder: RTL and testbench

//  Decode-side counterpart of the encoding binder. The encoder binds a level HV by a

---
 rtl/dec_unbinder.sv | 147 ++++++++++++++
 tb/tb_dec_unbinder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dec_unbinder.sv
// Feature-slot decoder: undoes the encoder's left rotate on a bound HV, then scans the
// level item memory and reports the level with the largest AND-overlap (lowest index on ties).
module dec_unbinder #(
  parameter int HV_DIM     = 1024,
  parameter int SHIFT      = 0,
  parameter int NUM_LEVELS = 16,
  parameter int LVL_W      = $clog2(NUM_LEVELS),
  parameter int CNT_W      = $clog2(HV_DIM + 1)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_decoding,
  input  logic [HV_DIM-1:0] bound_hv,
  output logic              lvl_rd_en,
  output logic [LVL_W-1:0]  lvl_rd_addr,
  input  logic [HV_DIM-1:0] lvl_rd_data,
  output logic              busy,
  output logic              done,
  output logic [HV_DIM-1:0] unbound_hv,
  output logic [LVL_W-1:0]  dec_level,
  output logic [CNT_W-1:0]  dec_score
);

  localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(NUM_LEVELS - 1);
  localparam int DEPTH = $clog2(HV_DIM);
  localparam int PAD   = 1 << DEPTH;

  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [HV_DIM-1:0]  rot_hv;
  logic [HV_DIM-1:0]  unbound_reg;
  logic [LVL_W-1:0]   scan_idx_reg;
  logic [LVL_W-1:0]   addr_reg;
  logic [LVL_W-1:0]   best_idx_reg, best_idx_next;
  logic [CNT_W-1:0]   best_score_reg, best_score_next;
  logic [LVL_W-1:0]   dec_level_reg;
  logic [CNT_W-1:0]   dec_score_reg;
  logic [PAD-1:0]     and_bits;
  logic [CNT_W-1:0]   overlap;
  logic               last_level;

  // Rotate right by SHIFT: pure wiring.
  genvar gi, gl;
  generate
    for (gi = 0; gi < HV_DIM; gi++) begin : g_rot
      assign rot_hv[gi] = bound_hv[(gi + SHIFT) % HV_DIM];
    end
  endgenerate

  // Balanced popcount tree, padded to a power of two with zero leaves.
  assign and_bits = PAD'(unbound_reg & lvl_rd_data);

  generate
    for (gl = 0; gl <= DEPTH; gl++) begin : g_lvl
      localparam int NODES = PAD >> gl;
      logic [CNT_W-1:0] sum [NODES];
      if (gl == 0) begin : g_leaf
        for (gi = 0; gi < NODES; gi++) begin : g_bit
          assign sum[gi] = CNT_W'(and_bits[gi]);
        end
      end else begin : g_add
        for (gi = 0; gi < NODES; gi++) begin : g_node
          assign sum[gi] = g_lvl[gl-1].sum[2*gi] + g_lvl[gl-1].sum[2*gi+1];
        end
      end
    end
  endgenerate

  assign overlap    = g_lvl[DEPTH].sum[0];
  assign last_level = (scan_idx_reg == LAST_LVL);

  // Strict compare keeps the earliest index on ties.
  always_comb begin
    best_idx_next   = best_idx_reg;
    best_score_next = best_score_reg;
    if (overlap > best_score_reg) begin
      best_idx_next   = scan_idx_reg;
      best_score_next = overlap;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_decoding) state_next = LOAD;
      LOAD:    state_next = SCAN;
      SCAN:    if (last_level) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    done      = (state_reg == DONE);
    lvl_rd_en = (state_reg == LOAD) || ((state_reg == SCAN) && !last_level);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      unbound_reg    <= '0;
      scan_idx_reg   <= '0;
      addr_reg       <= '0;
      best_idx_reg   <= '0;
      best_score_reg <= '0;
      dec_level_reg  <= '0;
      dec_score_reg  <= '0;
    end else begin
      if (state_reg == IDLE && start_decoding) begin
        unbound_reg    <= rot_hv;
        scan_idx_reg   <= '0;
        addr_reg       <= '0;
        best_idx_reg   <= '0;
        best_score_reg <= '0;
      end
      // Address advances with each issued read and parks on the last level.
      if (lvl_rd_en && addr_reg != LAST_LVL) begin
        addr_reg <= addr_reg + LVL_W'(1);
      end
      if (state_reg == SCAN) begin
        best_idx_reg   <= best_idx_next;
        best_score_reg <= best_score_next;
        if (last_level) begin
          dec_level_reg <= best_idx_next;
          dec_score_reg <= best_score_next;
        end else begin
          scan_idx_reg <= scan_idx_reg + LVL_W'(1);
        end
      end
    end
  end

  assign unbound_hv  = unbound_reg;
  assign lvl_rd_addr = addr_reg;
  assign dec_level   = dec_level_reg;
  assign dec_score   = dec_score_reg;

endmodule

// File: tb/tb_dec_unbinder.sv
// Directed bench for dec_unbinder at HV_DIM=16, SHIFT=3, NUM_LEVELS=16 with a registered
// level memory model; table vectors plus reset-abort, busy-ignore and back-to-back sequences.
module tb_dec_unbinder;

  localparam int HV_DIM = 16;
  localparam int SHIFT  = 3;
  localparam int NLVL   = 16;
  localparam int LVL_W  = 4;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              nrst;
  logic              start_decoding;
  logic [HV_DIM-1:0] bound_hv;
  logic              lvl_rd_en;
  logic [LVL_W-1:0]  lvl_rd_addr;
  logic [HV_DIM-1:0] lvl_rd_data;
  logic              busy;
  logic              done;
  logic [HV_DIM-1:0] unbound_hv;
  logic [LVL_W-1:0]  dec_level;
  logic [CNT_W-1:0]  dec_score;

  dec_unbinder #(.HV_DIM(HV_DIM), .SHIFT(SHIFT), .NUM_LEVELS(NLVL)) dut (
    .clk(clk), .nrst(nrst), .start_decoding(start_decoding), .bound_hv(bound_hv),
    .lvl_rd_en(lvl_rd_en), .lvl_rd_addr(lvl_rd_addr), .lvl_rd_data(lvl_rd_data),
    .busy(busy), .done(done), .unbound_hv(unbound_hv),
    .dec_level(dec_level), .dec_score(dec_score)
  );

  always #5 clk = ~clk;

  logic [HV_DIM-1:0] level_mem [NLVL];
  initial lvl_rd_data = '0;
  always @(posedge clk) if (lvl_rd_en) lvl_rd_data <= level_mem[lvl_rd_addr];

  // Read-strobe and done monitors, sampled mid-cycle.
  int rd_cnt = 0, addr_errs = 0, rd_seq = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (lvl_rd_en) begin
      if (lvl_rd_addr != rd_seq[LVL_W-1:0]) addr_errs++;
      rd_seq++;
      rd_cnt++;
    end else begin
      rd_seq = 0;
    end
    if (done === 1'b1) done_cnt++;
  end

  typedef struct {
    logic [HV_DIM-1:0] bound;
    logic [HV_DIM-1:0] bg;
    int                ia;
    logic [HV_DIM-1:0] va;
    int                ib;
    logic [HV_DIM-1:0] vb;
    logic [HV_DIM-1:0] exp_unb;
    logic [LVL_W-1:0]  exp_lvl;
    logic [CNT_W-1:0]  exp_score;
  } vec_t;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fill(input vec_t v);
    for (int i = 0; i < NLVL; i++) level_mem[i] = v.bg;
    level_mem[v.ia] = v.va;
    level_mem[v.ib] = v.vb;
  endtask

  // Starts in the cycle after the call, returns at +1 in the done cycle (or on timeout).
  task automatic run_decode(input string tag, input vec_t v, input bit glitch);
    int lat, rd0, ae0;
    fill(v);
    @(posedge clk); #1;
    start_decoding = 1'b1;
    bound_hv = v.bound;
    rd0 = rd_cnt;
    ae0 = addr_errs;
    @(posedge clk); #1;
    start_decoding = 1'b0;
    bound_hv = ~v.bound;
    chk({tag, "_busy_t1"}, 32'(busy), 32'd1);
    chk({tag, "_unbound_t1"}, 32'(unbound_hv), 32'(v.exp_unb));
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (glitch) start_decoding = (lat == 6 || lat == 12);
    end
    start_decoding = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(NLVL + 2));
    chk({tag, "_level"}, 32'(dec_level), 32'(v.exp_lvl));
    chk({tag, "_score"}, 32'(dec_score), 32'(v.exp_score));
    chk({tag, "_unbound_done"}, 32'(unbound_hv), 32'(v.exp_unb));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    #4;
    chk({tag, "_rd_count"}, 32'(rd_cnt - rd0), 32'(NLVL));
    chk({tag, "_addr_order_errs"}, 32'(addr_errs - ae0), 32'd0);
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rd_en"}, 32'(lvl_rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(lvl_rd_addr), 32'd0);
    chk({tag, "_unbound"}, 32'(unbound_hv), 32'd0);
    chk({tag, "_level"}, 32'(dec_level), 32'd0);
    chk({tag, "_score"}, 32'(dec_score), 32'd0);
  endtask

  vec_t vecs [6];
  int   d0;

  initial begin
    // bound, bg, ia, va, ib, vb, unbound, level, score
    vecs[0] = '{16'h0088, 16'h0000, 5,  16'h0011, 5,  16'h0011, 16'h0011, 4'd5,  5'd2};
    vecs[1] = '{16'h0088, 16'h0000, 2,  16'h0011, 9,  16'h0011, 16'h0011, 4'd2,  5'd2};
    vecs[2] = '{16'h0000, 16'hFFFF, 0,  16'hFFFF, 1,  16'hFFFF, 16'h0000, 4'd0,  5'd0};
    vecs[3] = '{16'hFFFF, 16'h0000, 15, 16'hFFFF, 15, 16'hFFFF, 16'hFFFF, 4'd15, 5'd16};
    vecs[4] = '{16'h0088, 16'h000F, 7,  16'h0111, 7,  16'h0111, 16'h0011, 4'd7,  5'd2};
    vecs[5] = '{16'h8001, 16'h0000, 11, 16'h3000, 4,  16'h1000, 16'h3000, 4'd11, 5'd2};

    nrst = 1'b1;
    start_decoding = 1'b0;
    bound_hv = '0;
    for (int i = 0; i < NLVL; i++) level_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b0;
    chk_idle("reset");

    // Table vectors, issued back-to-back (each start lands in the cycle after done).
    for (int i = 0; i < 6; i++) begin
      run_decode($sformatf("vec%0d", i), vecs[i], 1'b0);
      $display("vec%0d: bound=%h level=%0d score=%0d", i, vecs[i].bound, dec_level, dec_score);
    end
    @(posedge clk); #1;
    chk("after_done_busy", 32'(busy), 32'd0);

    // Start pulses while busy must not disturb the running decode.
    run_decode("glitch", vecs[0], 1'b1);
    $display("glitch: level=%0d score=%0d", dec_level, dec_score);
    repeat (25) begin
      @(posedge clk); #1;
      if (busy !== 1'b0) break;
    end
    chk("glitch_no_requeue", 32'(busy), 32'd0);

    // Reset in the middle of a scan aborts without a done pulse.
    run_decode("pre_abort", vecs[5], 1'b0);
    fill(vecs[0]);
    @(posedge clk); #1;
    start_decoding = 1'b1;
    bound_hv = vecs[0].bound;
    @(posedge clk); #1;
    start_decoding = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    d0 = done_cnt;
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b0;
    chk_idle("abort");
    @(posedge clk); #1;
    chk("abort_next_busy", 32'(busy), 32'd0);
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    $display("abort: done pulses after reset=%0d", done_cnt - d0);

    run_decode("recover", vecs[4], 1'b0);
    $display("recover: level=%0d score=%0d", dec_level, dec_score);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
